branch_predictor: RTL and testbench
===================================

# branch_predictor

Branch target buffer with 2-bit saturating direction counters for the pipelined RV32 core. It is looked up by IF with the fetch PC to choose the next PC. In ID it is updated with the resolved outcome of each branch or jump: the `c` output of the 32-bit branch comparator for conditional branches, 1 for JAL/JALR. It flags mispredictions and supplies the corrected PC so the hazard unit can flush IF.

## Interface
- `ENTRIES`, default 16: number of table entries; power of two, at least 2.
- `INDEX_W`, default 4: log2(`ENTRIES`).
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_if`  in  32  fetch PC to look up.
- `pred_taken`  out  1  prediction for `pc_if`: 1 means taken.
- `pred_target`  out  32  predicted next PC for `pc_if`.
- `upd_valid`  in  1  ID holds a resolved branch/jump this cycle (low when ID is stalled or bubbled).
- `upd_pc`  in  32  PC of the resolved instruction.
- `upd_is_branch`  in  1  1 = conditional branch; 0 = JAL/JALR.
- `upd_taken`  in  1  actual direction (comparator result, or 1 for jumps).
- `upd_target`  in  32  actual taken target.
- `upd_pred_taken`  in  1  prediction that was made for this instruction in IF, carried down the pipeline.
- `upd_pred_target`  in  32  predicted target carried down the pipeline.
- `mispredict`  out  1  flush request.
- `redirect_pc`  out  32  correct next PC when `mispredict` is 1.
- `br_count`  out  32  number of resolved updates.
- `miss_count`  out  32  number of mispredictions.

## Operation
- Entry fields: `valid`, `tag` = pc[31:INDEX_W+2], `target`[31:0], `ctr`[1:0].
- Index = pc[INDEX_W+1:2]. pc[1:0] is ignored.
- Lookup is combinational:
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = entry `target` when `pred_taken`, else `pc_if`+4 (32-bit wrap).
- Resolution is combinational:
  - actual_next = `upd_taken` ? `upd_target` : `upd_pc`+4.
  - `redirect_pc` = actual_next at all times.
  - `mispredict` = `upd_valid` && !`rst` && (`upd_pred_taken` != `upd_taken` || (`upd_taken` && `upd_pred_target` != `upd_target`)).
- Table update on a clock edge with `upd_valid` && !`rst`:
  - Hit at `upd_pc`, conditional branch: `ctr` saturating +1 if taken, -1 if not (range 0..3). `target` <= `upd_target` only if taken.
  - Hit, jump: `ctr` <= 3, `target` <= `upd_target`.
  - Miss and taken: allocate and overwrite unconditionally (no replacement policy). Set `valid`=1, `tag`, `target`=`upd_target`, `ctr` = 2 for a branch or 3 for a jump.
  - Miss and not taken: no table change.
- Statistics, on a clock edge with !`rst`:
  - `br_count` += 1 when `upd_valid`.
  - `miss_count` += 1 when `mispredict`.
  - Both wrap modulo 2^32.

## Timing
- Lookup latency: 0 cycles (same-cycle IF use).
- Update latency: written at the edge; visible to lookup from the next cycle.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents. No bypass.
- Reset, including mid-operation: at the first rising edge with `rst`=1, every `valid` <= 0, every `ctr` <= 1, and `br_count` = `miss_count` = 0.
  - While `rst`=1: `pred_taken` = 0 from the edge onward and `pred_target` = `pc_if`+4. `mispredict` = 0 combinationally. Update inputs are ignored.
  - First usable update is on the edge after `rst` falls.
- Stalls: upstream holds `upd_valid` low, so counters and table are untouched. An update held for N cycles with `upd_valid` high counts N times; the caller must not do this.

## Test plan
- Reset, then `pc_if`=0x100 → `pred_taken`=0, `pred_target`=0x104. After reset, `br_count`=`miss_count`=0.
- Cold branch: `upd_pc`=0x100, `upd_taken`=1, `upd_target`=0x80, pred_taken=0 → `mispredict`=1 and `redirect_pc`=0x80 the same cycle. Next cycle `pc_if`=0x100 gives `pred_taken`=1, `pred_target`=0x80, ctr=2. `miss_count`=1.
- Hysteresis: from ctr=2, one not-taken update → ctr=1, `pred_taken`=0. A second not-taken → ctr=0. Two takens → ctr=2, `pred_taken`=1. Four takens saturate at 3.
- Target change: entry 0x100→0x80; update taken with `upd_target`=0x200 and `upd_pred_target`=0x80 → `mispredict`=1, `redirect_pc`=0x200. Next lookup gives 0x200.
- Aliasing: entry at 0x100 (ENTRIES=16). Lookup 0x140 (same index, different tag) → miss, `pred_taken`=0. A taken JAL update at 0x140 → 0x300 overwrites the entry, and 0x100 then misses.
- Same-cycle conflict and reset: update and lookup at 0x100 in the same cycle → lookup shows old value. Assert `rst` while the table is populated → next cycle all lookups miss and both counters read 0.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Function : Direct-mapped BTB with 2-bit saturating direction counters,
//            same-cycle lookup for IF and resolution/update from ID.
// Revision : 1.0
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);

    localparam int c_tag_w = 32 - INDEX_W - 2;

    logic               r_valid  [ENTRIES];
    logic [c_tag_w-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [31:0]        r_br_count;
    logic [31:0]        r_miss_count;

    logic [INDEX_W-1:0] w_lk_idx;
    logic [c_tag_w-1:0] w_lk_tag;
    logic               w_lk_hit;
    logic [INDEX_W-1:0] w_up_idx;
    logic [c_tag_w-1:0] w_up_tag;
    logic               w_up_hit;
    logic               w_up_en;

    assign w_lk_idx = pc_if[INDEX_W+1:2];
    assign w_lk_tag = pc_if[31:INDEX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign pred_target = pred_taken ? r_target[w_lk_idx] : pc_if + 32'd4;

    assign w_up_idx = upd_pc[INDEX_W+1:2];
    assign w_up_tag = upd_pc[31:INDEX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_en  = upd_valid && !rst;

    assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    assign mispredict  = w_up_en &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));

    assign br_count   = r_br_count;
    assign miss_count = r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'd1;
            end
            r_br_count   <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (upd_valid) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (mispredict) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (w_up_en) begin
                if (w_up_hit) begin
                    if (upd_is_branch) begin
                        if (upd_taken) begin
                            if (r_ctr[w_up_idx] != 2'd3) begin
                                r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                            end
                            r_target[w_up_idx] <= upd_target;
                        end else if (r_ctr[w_up_idx] != 2'd0) begin
                            r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                        end
                    end else begin
                        r_ctr[w_up_idx]    <= 2'd3;
                        r_target[w_up_idx] <= upd_target;
                    end
                end else if (upd_taken) begin
                    // Allocation always evicts whatever occupies the index.
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= upd_target;
                    r_ctr[w_up_idx]    <= upd_is_branch ? 2'd2 : 2'd3;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Function : Directed, self-checking bench for branch_predictor.
// Revision : 1.0
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int n_vec  = 0;
    int n_miss = 0;

    branch_predictor #(.ENTRIES(16), .INDEX_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_if           (pc_if),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_is_branch   (upd_is_branch),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .br_count        (br_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = v;
        upd_pc          = pc;
        upd_is_branch   = br;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        #1;
    endtask

    // Commit the current inputs at the rising edge, then return mid-low-phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        pc_if = 32'h100;
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_mispredict", {31'b0, mispredict}, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        tick();
        rst = 1'b0;
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_ignored_upd", {31'b0, pred_taken}, 32'd0);
        chk("rst_ignored_cnt", br_count, 32'd0);

        // Cold branch allocates with ctr=2
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
        chk("cold_mispredict", {31'b0, mispredict}, 32'd1);
        chk("cold_redirect", redirect_pc, 32'h80);
        chk("cold_same_cycle_pred", {31'b0, pred_taken}, 32'd0);
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("cold_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("cold_pred_target", pred_target, 32'h80);
        chk("cold_br_count", br_count, 32'd1);
        chk("cold_miss_count", miss_count, 32'd1);

        // Hysteresis: 2 -> 1 -> 0 -> 1 -> 2 -> 3 (saturated) -> 2 -> 1
        upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("nt1_mispredict", {31'b0, mispredict}, 32'd1);
        chk("nt1_redirect", redirect_pc, 32'h104);
        tick();
        chk("nt1_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("nt1_pred_target", pred_target, 32'h104);
        upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h104);
        chk("nt2_mispredict", {31'b0, mispredict}, 32'd0);
        tick();
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        chk("t1_from0_pred", {31'b0, pred_taken}, 32'd0);
        tick();
        chk("t2_from1_pred", {31'b0, pred_taken}, 32'd1);
        chk("t2_target", pred_target, 32'h80);
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("t_correct_no_mispredict", {31'b0, mispredict}, 32'd0);
        tick();
        tick();
        tick();
        tick();
        upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        chk("sat_nt1_pred", {31'b0, pred_taken}, 32'd1);
        tick();
        chk("sat_nt2_pred", {31'b0, pred_taken}, 32'd0);
        chk("hyst_br_count", br_count, 32'd11);
        chk("hyst_miss_count", miss_count, 32'd6);

        // Target change on a hitting, predicted-taken branch
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h80);
        chk("tgt_mispredict", {31'b0, mispredict}, 32'd1);
        chk("tgt_redirect", redirect_pc, 32'h200);
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("tgt_new_target", pred_target, 32'h200);
        chk("tgt_miss_count", miss_count, 32'd8);

        // Aliasing: 0x140 shares the index of 0x100
        pc_if = 32'h140;
        #1;
        chk("alias_miss_pred", {31'b0, pred_taken}, 32'd0);
        chk("alias_miss_target", pred_target, 32'h144);
        upd(1'b1, 32'h140, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144);
        chk("alias_jal_mispredict", {31'b0, mispredict}, 32'd1);
        chk("alias_jal_redirect", redirect_pc, 32'h300);
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("alias_new_pred", {31'b0, pred_taken}, 32'd1);
        chk("alias_new_target", pred_target, 32'h300);
        pc_if = 32'h100;
        #1;
        chk("alias_old_evicted", {31'b0, pred_taken}, 32'd0);
        chk("alias_old_target", pred_target, 32'h104);

        // Jump hit retargets
        upd(1'b1, 32'h140, 1'b0, 1'b1, 32'h340, 1'b1, 32'h300);
        chk("jhit_mispredict", {31'b0, mispredict}, 32'd1);
        tick();

        // Same-cycle lookup and update: lookup sees the pre-update entry
        pc_if = 32'h140;
        upd(1'b1, 32'h140, 1'b1, 1'b1, 32'h400, 1'b1, 32'h340);
        chk("conflict_old_target", pred_target, 32'h340);
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("conflict_new_target", pred_target, 32'h400);
        pc_if = 32'h142;
        #1;
        chk("low_bits_ignored", pred_target, 32'h400);
        chk("conflict_br_count", br_count, 32'd16);
        chk("conflict_miss_count", miss_count, 32'd11);

        // 32-bit wrap of the fall-through PC
        pc_if = 32'hFFFF_FFFC;
        upd(1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("wrap_pred_target", pred_target, 32'h0);
        chk("wrap_redirect", redirect_pc, 32'h0);
        chk("stall_mispredict", {31'b0, mispredict}, 32'd0);
        tick();
        chk("stall_br_count", br_count, 32'd16);
        chk("stall_miss_count", miss_count, 32'd11);

        // Reset while populated
        rst = 1'b1;
        pc_if = 32'h140;
        upd(1'b1, 32'h140, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
        chk("midrst_mispredict", {31'b0, mispredict}, 32'd0);
        tick();
        chk("midrst_pred", {31'b0, pred_taken}, 32'd0);
        chk("midrst_target", pred_target, 32'h144);
        chk("midrst_br_count", br_count, 32'd0);
        chk("midrst_miss_count", miss_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
